// File: rtl/pos_delay_line.sv
// pos_delay_line: stallable multi-channel delay line with per-stage valid bits.
// Carries CH lanes of W-bit position data through DEPTH register stages so
// that the data lines up with the latency of the downstream timing and draw
// stages. Supports a stall (en), a synchronous flush, occupancy reporting and
// an optional hold-last-valid mode that keeps bubble data off the output.
module pos_delay_line #(
    parameter int W         = 12,
    parameter int CH        = 2,
    parameter int DEPTH     = 2,
    parameter int HOLD_LAST = 1
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         valid_in,
    input  logic [CH*W-1:0]              data_in,
    output logic [CH*W-1:0]              data_out,
    output logic                         valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int DW = CH * W;
    localparam int FW = $clog2(DEPTH + 1);
    localparam bit HOLD = (HOLD_LAST == 1);

    // Reject parameter values the datapath is not built for.
    if (W < 1) begin : g_bad_w
        $error("pos_delay_line: W must be >= 1");
    end
    if (CH < 1) begin : g_bad_ch
        $error("pos_delay_line: CH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("pos_delay_line: DEPTH must be >= 1");
    end
    if (HOLD_LAST != 0 && HOLD_LAST != 1) begin : g_bad_hold
        $error("pos_delay_line: HOLD_LAST must be 0 or 1");
    end

    logic [DW-1:0]  d     [DEPTH];
    logic [DEPTH-1:0] v;

    // Source of each stage: stage 0 takes the input, stage k takes stage k-1.
    // Widening by one entry keeps every index in range, including DEPTH=1.
    logic [DEPTH:0] v_src;
    logic [DW-1:0]  d_src [DEPTH+1];
    logic [DW-1:0]  d_nxt [DEPTH];
    logic [FW:0]    fill_sum;

    assign v_src = {v, valid_in};

    // Build the per-stage data source list.
    always_comb begin
        d_src[0] = data_in;
        for (int k = 0; k < DEPTH; k++) begin
            d_src[k+1] = d[k];
        end
    end

    // In hold-last mode a stage only loads when the sample reaching it is
    // valid, so each stage keeps the most recent valid sample it has seen.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            d_nxt[k] = (!HOLD || v_src[k]) ? d_src[k] : d[k];
        end
    end

    // One sample enters and one leaves per advance, so the extra bit only
    // absorbs the intermediate borrow; the result always fits in FW bits.
    assign fill_sum = {1'b0, fill}
                    + {{FW{1'b0}}, valid_in}
                    - {{FW{1'b0}}, v[DEPTH-1]};

    // Stage registers: reset, then flush, then advance; otherwise hold.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
            v    <= '0;
            fill <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
            v    <= '0;
            fill <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= d_nxt[k];
            end
            v    <= v_src[DEPTH-1:0];
            fill <= fill_sum[FW-1:0];
        end
    end

    assign data_out  = d[DEPTH-1];
    assign valid_out = v[DEPTH-1];

endmodule

// File: tb/tb_pos_delay_line.sv
// Testbench for pos_delay_line. Five instances with different DEPTH and
// HOLD_LAST settings share one stimulus stream; a history-based reference
// model predicts each instance's outputs from the sequence of advances.
module tb_pos_delay_line;

    localparam int NI = 5;
    localparam int DEP [NI] = '{3, 2, 2, 4, 1};
    localparam bit HLD [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic        pclk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        valid_in;
    logic [23:0] data_in;

    logic [23:0] do0, do1, do2, do3, do4;
    logic        vo0, vo1, vo2, vo3, vo4;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [2:0]  f3;
    logic [0:0]  f4;

    logic [23:0] act_d [NI];
    logic        act_v [NI];
    logic [31:0] act_f [NI];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        v;
        logic [23:0] d;
    } rec_t;

    // Every advance since the last reset/flush, oldest first.
    rec_t hist[$];

    pos_delay_line #(.W(12), .CH(2), .DEPTH(3), .HOLD_LAST(0)) u0 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .data_out(do0), .valid_out(vo0), .fill(f0));
    pos_delay_line u1 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .data_out(do1), .valid_out(vo1), .fill(f1));
    pos_delay_line #(.W(12), .CH(2), .DEPTH(2), .HOLD_LAST(0)) u2 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .data_out(do2), .valid_out(vo2), .fill(f2));
    pos_delay_line #(.W(12), .CH(2), .DEPTH(4), .HOLD_LAST(1)) u3 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .data_out(do3), .valid_out(vo3), .fill(f3));
    pos_delay_line #(.W(12), .CH(2), .DEPTH(1), .HOLD_LAST(0)) u4 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .data_out(do4), .valid_out(vo4), .fill(f4));

    assign act_d[0] = do0;  assign act_v[0] = vo0;  assign act_f[0] = 32'(f0);
    assign act_d[1] = do1;  assign act_v[1] = vo1;  assign act_f[1] = 32'(f1);
    assign act_d[2] = do2;  assign act_v[2] = vo2;  assign act_f[2] = 32'(f2);
    assign act_d[3] = do3;  assign act_v[3] = vo3;  assign act_f[3] = 32'(f3);
    assign act_d[4] = do4;  assign act_v[4] = vo4;  assign act_f[4] = 32'(f4);

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // A sample is at the output once DEPTH further advances have happened.
    // Occupancy is the number of valid samples among the newest DEPTH
    // advances. Hold-last shows the newest valid sample that has reached
    // the output position; otherwise the output shows whatever got there.
    function automatic void model(input int dep, input bit hold,
                                  output logic ev, output logic [23:0] ed,
                                  output int ef);
        int n;
        int top;
        n   = hist.size();
        top = n - dep;
        ev  = 1'b0;
        ed  = '0;
        ef  = 0;
        for (int k = top; k < n; k++) begin
            if (k >= 0 && hist[k].v) ef++;
        end
        if (top >= 0) begin
            ev = hist[top].v;
            if (!hold) begin
                ed = hist[top].d;
            end else begin
                for (int k = top; k >= 0; k--) begin
                    if (hist[k].v) begin
                        ed = hist[k].d;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit e, input bit f, input bit vi, input logic [23:0] di);
        en       = e;
        flush    = f;
        valid_in = vi;
        data_in  = di;
        @(posedge pclk);
        if (f) hist.delete();
        else if (e) hist.push_back('{vi, di});
        #1;
    endtask

    task automatic test_reset();
        logic ev; logic [23:0] ed; int ef;
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; valid_in = 1'b1; data_in = 24'h5A5A5A;
        hist.delete();
        #1;
        for (int i = 0; i < NI; i++) begin
            model(DEP[i], HLD[i], ev, ed, ef);
            n_cmp += 3;
            if (act_v[i] !== ev) begin n_err++; $display("FAIL reset u%0d valid_out got %b want %b", i, act_v[i], ev); end
            if (act_d[i] !== ed) begin n_err++; $display("FAIL reset u%0d data_out got %h want %h", i, act_d[i], ed); end
            if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL reset u%0d fill got %0d want %0d", i, act_f[i], ef); end
        end
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic ev; logic [23:0] ed; int ef;
        int want_fill [4] = '{1, 1, 1, 0};
        step(1'b0, 1'b1, 1'b0, 24'h0);
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b0, s == 0, (s == 0) ? 24'h045123 : 24'h000000);
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL latency u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL latency u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL latency u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
            n_cmp += 2;
            if (act_f[0] !== 32'(want_fill[s])) begin n_err++; $display("FAIL latency_fill step %0d got %0d want %0d", s, act_f[0], want_fill[s]); end
            if (vo0 !== (s == 2)) begin n_err++; $display("FAIL latency_valid step %0d got %b want %b", s, vo0, s == 2); end
            if (s == 2) begin
                n_cmp++;
                if (do0 !== 24'h045123) begin n_err++; $display("FAIL latency_data got %h want 045123", do0); end
            end
        end
    endtask

    task automatic test_stall();
        logic ev; logic [23:0] ed; int ef;
        bit          e_t  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit          v_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [23:0] d_t  [8] = '{24'h00A001, 24'h00B002, 24'h777777, 24'h777777,
                                  24'h00C003, 24'h000000, 24'h000000, 24'h000000};
        logic [1:0]  fill_before;
        step(1'b0, 1'b1, 1'b0, 24'h0);
        for (int s = 0; s < 8; s++) begin
            fill_before = f0;
            step(e_t[s], 1'b0, v_t[s], d_t[s]);
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL stall u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL stall u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL stall u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
            if (!e_t[s]) begin
                n_cmp++;
                if (f0 !== fill_before) begin n_err++; $display("FAIL stall_fill step %0d got %0d want %0d", s, f0, fill_before); end
            end
        end
    endtask

    task automatic test_hold_last();
        logic ev; logic [23:0] ed; int ef;
        step(1'b0, 1'b1, 1'b0, 24'h0);
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 1'b0, s == 0, (s == 0) ? 24'h000200 : 24'hFFFFFF);
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL hold u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL hold u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL hold u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
            if (s >= 1) begin
                n_cmp += 2;
                if (do1 !== 24'h000200) begin n_err++; $display("FAIL hold_data step %0d got %h want 000200", s, do1); end
                if (vo1 !== (s == 1)) begin n_err++; $display("FAIL hold_valid step %0d got %b want %b", s, vo1, s == 1); end
            end
            if (s >= 2) begin
                n_cmp++;
                if (do2 !== 24'hFFFFFF) begin n_err++; $display("FAIL nohold_data step %0d got %h want ffffff", s, do2); end
            end
        end
    endtask

    task automatic test_full();
        logic ev; logic [23:0] ed; int ef;
        logic [11:0] x;
        step(1'b0, 1'b1, 1'b0, 24'h0);
        for (int s = 1; s <= 16; s++) begin
            x = 12'(s - 1);
            step(1'b1, 1'b0, 1'b1, {x ^ 12'hABC, x});
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL full u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL full u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL full u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
            if (s >= 4) begin
                n_cmp += 2;
                if (f3 !== 3'd4) begin n_err++; $display("FAIL full_fill step %0d got %0d want 4", s, f3); end
                if (do3[11:0] !== 12'(s - 4)) begin n_err++; $display("FAIL full_data step %0d got %0d want %0d", s, do3[11:0], s - 4); end
            end
        end
    endtask

    task automatic test_flush();
        logic ev; logic [23:0] ed; int ef;
        step(1'b0, 1'b1, 1'b0, 24'h0);
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 1'b1, 24'h010010 + 24'(s));
        n_cmp++;
        if (f0 !== 2'd3) begin n_err++; $display("FAIL flush_prefill got %0d want 3", f0); end
        step(1'b1, 1'b1, 1'b1, 24'hABCDEF);
        n_cmp += 3;
        if (f0 !== 2'd0) begin n_err++; $display("FAIL flush_fill got %0d want 0", f0); end
        if (vo0 !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", vo0); end
        if (do0 !== 24'h0) begin n_err++; $display("FAIL flush_data got %h want 000000", do0); end
        for (int s = 0; s < 5; s++) begin
            step(1'b1, 1'b0, 1'b0, 24'h000000);
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL flush u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL flush u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL flush u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
        end
    endtask

    task automatic test_random();
        logic ev; logic [23:0] ed; int ef;
        for (int s = 0; s < 400; s++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
                 $urandom_range(1, 0) == 1, 24'($urandom));
            for (int i = 0; i < NI; i++) begin
                model(DEP[i], HLD[i], ev, ed, ef);
                n_cmp += 3;
                if (act_v[i] !== ev) begin n_err++; $display("FAIL random u%0d valid_out got %b want %b", i, act_v[i], ev); end
                if (act_d[i] !== ed) begin n_err++; $display("FAIL random u%0d data_out got %h want %h", i, act_d[i], ed); end
                if (act_f[i] !== 32'(ef)) begin n_err++; $display("FAIL random u%0d fill got %0d want %0d", i, act_f[i], ef); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] a;
        logic [23:0] b;
        for (int s = 0; s < 6; s++) step(1'b1, 1'b0, 1'b1, 24'h300300 + 24'(s));
        #2;
        rst_n = 1'b0;
        #1;
        hist.delete();
        for (int i = 0; i < NI; i++) begin
            n_cmp += 3;
            if (act_v[i] !== 1'b0) begin n_err++; $display("FAIL async_rst u%0d valid_out got %b want 0", i, act_v[i]); end
            if (act_d[i] !== 24'h0) begin n_err++; $display("FAIL async_rst u%0d data_out got %h want 000000", i, act_d[i]); end
            if (act_f[i] !== 32'd0) begin n_err++; $display("FAIL async_rst u%0d fill got %0d want 0", i, act_f[i]); end
        end
        en = 1'b1; valid_in = 1'b1; data_in = 24'h999999;
        @(posedge pclk);
        #1;
        n_cmp += 2;
        if (vo4 !== 1'b0) begin n_err++; $display("FAIL rst_hold valid_out got %b want 0", vo4); end
        if (do4 !== 24'h0) begin n_err++; $display("FAIL rst_hold data_out got %h want 000000", do4); end
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            step(1'b1, 1'b0, 1'b1, a);
            n_cmp += 2;
            if (vo4 !== 1'b1) begin n_err++; $display("FAIL d1_valid step %0d got %b want 1", s, vo4); end
            if (do4 !== a) begin n_err++; $display("FAIL d1_data step %0d got %h want %h", s, do4, a); end
            step(1'b1, 1'b0, 1'b0, b);
            n_cmp += 3;
            if (vo4 !== 1'b0) begin n_err++; $display("FAIL d1_bubble step %0d got %b want 0", s, vo4); end
            if (do4 !== b) begin n_err++; $display("FAIL d1_bubble_data step %0d got %h want %h", s, do4, b); end
            if (f4 !== 1'b0) begin n_err++; $display("FAIL d1_fill step %0d got %0d want 0", s, f4); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_hold_last();
        test_full();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
